cpu_dpi_arbiter: RTL and testbench

- Merges N_SRC per-CPU 64-bit valid/ready streams into one output stream. Sources are cpu_dpi_server-style producers.
- Output carries the winning source index, so one downstream consumer can be shared by all CPU servers.
- Arbitration is round-robin with a bounded burst: a source keeps the grant for up to MAX_BURST consecutive beats.
- Output is registered, giving 1-cycle latency with full throughput.

---
 rtl/cpu_dpi_arbiter.sv | 141 ++++++++++++++
 tb/tb_cpu_dpi_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_dpi_arbiter.sv
// Round-robin, burst-bounded merge of N_SRC valid/ready streams into one registered output.
// Optional per-source beat counters: define CPU_DPI_ARBITER_STATS_EN.
module cpu_dpi_arbiter #(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 4,
  localparam int IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        src_vld,
  output logic [N_SRC-1:0]        src_rdy,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_src
`ifdef CPU_DPI_ARBITER_STATS_EN
  ,
  output logic [N_SRC*32-1:0]     beat_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_out_vld;
  logic [DATA_W-1:0]   r_out_data;
  logic [IDX_W-1:0]    r_out_src;
  logic [IDX_W-1:0]    r_owner;
  logic [CNT_W-1:0]    r_burst_cnt;

  logic                w_load;
  logic                w_cont;
  logic                w_has_win;
  logic                w_grant;
  logic [IDX_W-1:0]    w_win;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_data;

  // Winner selection: continue the burst, else nearest valid source after owner (owner last).
  always_comb begin
    w_load    = ~r_out_vld | out_rdy;
    w_cont    = (r_state == BURST) && src_vld[r_owner] && (r_burst_cnt < CNT_W'(MAX_BURST));
    w_win     = r_owner;
    w_has_win = 1'b0;
    w_idx     = '0;
    if (w_cont) begin
      w_win     = r_owner;
      w_has_win = 1'b1;
    end else begin
      // Walk from the farthest candidate inward so the nearest valid one is kept.
      for (int k = N_SRC; k >= 1; k--) begin
        w_idx = IDX_W'((int'(r_owner) + k) % N_SRC);
        if (src_vld[w_idx]) begin
          w_win     = w_idx;
          w_has_win = 1'b1;
        end else begin
          w_has_win = w_has_win;
        end
      end
    end
  end

  assign w_grant = w_load & w_has_win & ~rst;

  // Payload mux and one-hot ready for the granted source.
  always_comb begin
    w_data  = '0;
    src_rdy = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (IDX_W'(i) == w_win) begin
        w_data     = src_data[i*DATA_W +: DATA_W];
        src_rdy[i] = w_grant;
      end else begin
        src_rdy[i] = 1'b0;
      end
    end
  end

  // Output register, burst tracking and IDLE/BURST state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_owner     <= IDX_W'(N_SRC - 1);
      r_burst_cnt <= '0;
    end else if (w_load) begin
      case (w_has_win)
        1'b1: begin
          r_out_vld  <= 1'b1;
          r_out_data <= w_data;
          r_out_src  <= w_win;
          r_state    <= BURST;
          if (w_cont) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
          end else begin
            r_owner     <= w_win;
            r_burst_cnt <= CNT_W'(1);
          end
        end
        default: begin
          r_out_vld   <= 1'b0;
          r_state     <= IDLE;
          r_burst_cnt <= '0;
        end
      endcase
    end
  end

  assign out_vld  = r_out_vld;
  assign out_data = r_out_data;
  assign out_src  = r_out_src;

`ifdef CPU_DPI_ARBITER_STATS_EN
  logic [31:0] r_beat_cnt [N_SRC];

  // Per-source accepted-beat counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) r_beat_cnt[i] <= 32'd0;
    end else if (w_grant) begin
      r_beat_cnt[w_win] <= r_beat_cnt[w_win] + 32'd1;
    end
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_stats
    assign beat_cnt[g*32 +: 32] = r_beat_cnt[g];
  end
`else
  // No counters in this build.
`endif

endmodule

// File: tb/tb_cpu_dpi_arbiter.sv
// Random and directed stimulus on two arbiters (MAX_BURST 4 and 1) checked against a reference model.
module tb_cpu_dpi_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    src_vld = '0;
  logic [N*DW-1:0] src_data = '0;
  logic            out_rdy = 1'b1;
  logic [N-1:0]    rdy_a, rdy_b;
  logic            vld_a, vld_b;
  logic [DW-1:0]   data_a, data_b;
  logic [IW-1:0]   srco_a, srco_b;
`ifdef CPU_DPI_ARBITER_STATS_EN
  logic [N*32-1:0] bc_a, bc_b;
`endif

  cpu_dpi_arbiter #(.N_SRC(N), .DATA_W(DW), .MAX_BURST(4)) u_a (
    .clk(clk), .rst(rst), .src_vld(src_vld), .src_rdy(rdy_a), .src_data(src_data),
    .out_vld(vld_a), .out_rdy(out_rdy), .out_data(data_a), .out_src(srco_a)
`ifdef CPU_DPI_ARBITER_STATS_EN
    , .beat_cnt(bc_a)
`endif
  );

  cpu_dpi_arbiter #(.N_SRC(N), .DATA_W(DW), .MAX_BURST(1)) u_b (
    .clk(clk), .rst(rst), .src_vld(src_vld), .src_rdy(rdy_b), .src_data(src_data),
    .out_vld(vld_b), .out_rdy(out_rdy), .out_data(data_b), .out_src(srco_b)
`ifdef CPU_DPI_ARBITER_STATS_EN
    , .beat_cnt(bc_b)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          mb [2];
  bit          m_vld [2];
  logic [63:0] m_data [2];
  int          m_src [2];
  int          m_owner [2];
  int          m_cnt [2];
  bit          m_busy [2];
  int          m_stat [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Grant rule: stay with an unexhausted, still-valid owner; otherwise scan after owner, owner last.
  function automatic int pick(input int k);
    int i;
    if (m_busy[k] && src_vld[m_owner[k]] && m_cnt[k] < mb[k]) return m_owner[k];
    for (int j = 1; j <= N; j++) begin
      i = (m_owner[k] + j) % N;
      if (src_vld[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = 1'b0; m_data[k] = 64'd0; m_src[k] = 0;
      m_owner[k] = N - 1; m_cnt[k] = 0; m_busy[k] = 1'b0;
    end
    for (int i = 0; i < N; i++) m_stat[i] = 0;
  endtask

  task automatic check_outs();
    chk("A.out_vld", {63'd0, vld_a}, {63'd0, m_vld[0]});
    chk("A.out_data", data_a, m_data[0]);
    chk("A.out_src", {62'd0, srco_a}, m_src[0]);
    chk("B.out_vld", {63'd0, vld_b}, {63'd0, m_vld[1]});
    chk("B.out_data", data_b, m_data[1]);
    chk("B.out_src", {62'd0, srco_b}, m_src[1]);
`ifdef CPU_DPI_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) chk("A.beat_cnt", {32'd0, bc_a[i*32 +: 32]}, m_stat[i]);
`endif
  endtask

  // One clock: check registered outputs, drive inputs, check ready, advance the model.
  task automatic cycle(input logic [N-1:0] v, input logic r);
    bit          load;
    int          g;
    logic [63:0] e;
    logic [63:0] got;
    check_outs();
    src_vld = v;
    out_rdy = r;
    for (int i = 0; i < N; i++) src_data[i*DW +: DW] = {$urandom, $urandom};
    #1;
    for (int k = 0; k < 2; k++) begin
      load = !m_vld[k] || r;
      g    = load ? pick(k) : -1;
      e    = (g >= 0) ? (64'd1 << g) : 64'd0;
      got  = (k == 0) ? {60'd0, rdy_a} : {60'd0, rdy_b};
      chk((k == 0) ? "A.src_rdy" : "B.src_rdy", got, e);
      if (load) begin
        if (g >= 0) begin
          m_data[k] = src_data[g*DW +: DW];
          m_src[k]  = g;
          m_vld[k]  = 1'b1;
          if (m_busy[k] && g == m_owner[k] && m_cnt[k] < mb[k]) m_cnt[k]++;
          else begin
            m_owner[k] = g;
            m_cnt[k]   = 1;
          end
          m_busy[k] = 1'b1;
          if (k == 0) m_stat[g]++;
        end else begin
          m_vld[k]  = 1'b0;
          m_busy[k] = 1'b0;
          m_cnt[k]  = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset between clock edges; outputs and readies must clear at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst.A.out_vld", {63'd0, vld_a}, 64'd0);
    chk("rst.A.out_data", data_a, 64'd0);
    chk("rst.A.src_rdy", {60'd0, rdy_a}, 64'd0);
    chk("rst.B.out_vld", {63'd0, vld_b}, 64'd0);
    chk("rst.B.src_rdy", {60'd0, rdy_b}, 64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] v;
    mb[0] = 4;
    mb[1] = 1;
    model_reset();
    @(negedge clk);
    do_reset();

    for (int c = 0; c < 100; c++) cycle(4'b0001, 1'b1);
    for (int c = 0; c < 37; c++) cycle(4'b0100, 1'b1);
    check_outs();
`ifdef CPU_DPI_ARBITER_STATS_EN
    chk("stats.src0", {32'd0, bc_a[31:0]}, 64'd100);
    chk("stats.src1", {32'd0, bc_a[63:32]}, 64'd0);
    chk("stats.src2", {32'd0, bc_a[95:64]}, 64'd37);
    chk("stats.src3", {32'd0, bc_a[127:96]}, 64'd0);
`endif

    for (int c = 0; c < 3; c++) cycle(4'b0100, 1'b1);
    do_reset();
    for (int c = 0; c < 3; c++) cycle(4'b1110, 1'b1);

    for (int c = 0; c < 12; c++) cycle(4'b1111, 1'b1);
    for (int c = 0; c < 12; c++) cycle(4'b1001, 1'b1);
    for (int c = 0; c < 5; c++) cycle(4'b1111, 1'b0);
    for (int c = 0; c < 3; c++) cycle(4'b1111, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    for (int c = 0; c < 2; c++) cycle(4'b0010, 1'b1);
    for (int c = 0; c < 3; c++) cycle(4'b0100, 1'b1);
    for (int c = 0; c < 10; c++) cycle(4'b0010, 1'b1);

    for (int c = 0; c < 1500; c++) begin
      v = N'($urandom);
      if ($urandom_range(2) == 0) v = v & N'($urandom);
      cycle(v, $urandom_range(3) != 0);
    end
    check_outs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
